dmem_responder: RTL and testbench

//   Data-memory responder for the multicycle MIPS core. It is the memory-side end of the

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store controller and the data-memory responder.
// Optional macro: DMEM_BYTE_EN adds the 4-bit byte-lane enable signal "be".
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
`ifdef DMEM_BYTE_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
`ifdef DMEM_BYTE_EN
    output be,
`endif
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
`ifdef DMEM_BYTE_EN
    input  be,
`endif
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle MIPS core: captures one word access,
// waits WAIT cycles, then commits the write or load and pulses ready for one cycle.
// Optional macro: DMEM_BYTE_EN enables per-lane store masking and lane-aware alignment.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  generate
    if (WAIT > 15 || WAIT < 0) begin : g_wait_check
      $error("dmem_responder: WAIT must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state_q;
  logic [3:0]        wait_cnt_q;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  // Address bits above the array index are intentionally ignored (aliasing).
  wire unused_addr_bits = &{1'b0, bus.addr[31:ADDR_W+2]};

  // Access attributes as seen on the commit edge.
  logic              c_we_d;
  logic [ADDR_W+1:0] c_addr_d;
  logic [31:0]       c_wdata_d;
  logic [ADDR_W-1:0] c_idx_d;
  logic              c_mis_d;
  logic              commit_d;

`ifdef DMEM_BYTE_EN
  logic [3:0]        be_q;
  logic [3:0]        c_be_d;
`endif

  // With zero wait states the commit happens on the capture edge itself,
  // so the commit path must look at the live bus rather than the capture regs.
  generate
    if (WAIT == 0) begin : g_commit_direct
      assign c_we_d    = bus.we;
      assign c_addr_d  = bus.addr[ADDR_W+1:0];
      assign c_wdata_d = bus.wdata;
`ifdef DMEM_BYTE_EN
      assign c_be_d    = bus.be;
`endif
      assign commit_d  = !reset && (state_q == ST_IDLE) && bus.req;
    end else begin : g_commit_captured
      assign c_we_d    = we_q;
      assign c_addr_d  = addr_q;
      assign c_wdata_d = wdata_q;
`ifdef DMEM_BYTE_EN
      assign c_be_d    = be_q;
`endif
      assign commit_d  = !reset && (state_q == ST_WAIT) && (wait_cnt_q == 4'd0);
    end
  endgenerate

  assign c_idx_d = c_addr_d[ADDR_W+1:2];

  // Misalignment depends on which lanes are touched when byte enables exist.
  always_comb begin
    c_mis_d = 1'b0;
`ifdef DMEM_BYTE_EN
    case (c_be_d)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: c_mis_d = 1'b0;
      4'b0011, 4'b1100:                            c_mis_d = c_addr_d[0];
      default:                                     c_mis_d = (c_addr_d[1:0] != 2'b00);
    endcase
`else
    c_mis_d = (c_addr_d[1:0] != 2'b00);
`endif
  end

  // Array write port: only aligned stores write, and only on the commit edge.
  always_ff @(posedge clk) begin
    if (commit_d && c_we_d && !c_mis_d) begin
`ifdef DMEM_BYTE_EN
      for (int i = 0; i < 4; i++) begin
        if (c_be_d[i]) begin
          mem[c_idx_d][8*i +: 8] <= c_wdata_d[8*i +: 8];
        end
      end
`else
      mem[c_idx_d] <= c_wdata_d;
`endif
    end
  end

  // Control FSM with registered ready/busy/err and the load-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
`ifdef DMEM_BYTE_EN
      be_q       <= 4'd0;
`endif
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == ST_IDLE && bus.req) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr[ADDR_W+1:0];
        wdata_q <= bus.wdata;
`ifdef DMEM_BYTE_EN
        be_q    <= bus.be;
`endif
      end

      if (commit_d) begin
        state_q <= ST_RESP;
        ready_q <= 1'b1;
        busy_q  <= 1'b1;
        err_q   <= c_mis_d;
        if (!c_we_d && !c_mis_d) begin
          rdata_q <= mem[c_idx_d];
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.req) begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= WAIT_INIT;
              busy_q     <= 1'b1;
            end
          end
          ST_WAIT: begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
          ST_RESP: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=10, WAIT=2).
// Define DMEM_BYTE_EN for both bench and RTL to exercise the byte-lane scenario.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W (10),
    .WAIT   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One complete access: request at a falling edge, capture on the next rising
  // edge (counted as edge 1), then count rising edges until ready is seen.
  task automatic access(input logic we_v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be_v, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we_v;
    bus.addr  = a;
    bus.wdata = d;
`ifdef DMEM_BYTE_EN
    bus.be    = be_v;
`endif
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_capture addr=%h got=%b want=1", a, bus.busy);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL err_outside_ready addr=%h got=%b want=0", a, bus.err);
    end
    while (bus.ready !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = bus.rdata;
    er = bus.err;
    bus.req = 1'b0;
    $display("txn we=%0b addr=%h wdata=%h be=%h lat=%0d rdata=%h err=%0b",
             we_v, a, d, be_v, lat, rd, er);
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL after_ready addr=%h got ready=%b busy=%b want 0/0", a, bus.ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
`ifdef DMEM_BYTE_EN
    bus.be    = 4'hF;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
    checks++;
    if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d want=3", lat); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL store_err got=%b want=0", er); end
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL store_rdata_untouched got=%h want=0", rd); end
  endtask

  task automatic test_load();
    int lat; logic [31:0] rd; logic er;
    access(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h want=deadbeef", rd); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d want=3", lat); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL load_err got=%b want=0", er); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_rdata_hold got=%h want=deadbeef", bus.rdata);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h12, 32'h55555555, 4'hF, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL mis_store_err got=%b want=1", er); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL mis_store_latency got=%0d want=3", lat); end
    access(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_no_write got=%h want=deadbeef", rd); end
    access(1'b0, 32'h0000_0FF0, 32'h0, 4'hF, lat, rd, er);
    access(1'b0, 32'h11, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL mis_load_err got=%b want=1", er); end
    checks++;
    if (rd !== bus.rdata || bus.rdata === 32'hDEADBEEF) begin
      // rdata must keep the value of the previous completed load (word 0x3FC, never written -> X)
    end
    access(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    access(1'b0, 32'h13, 32'h0, 4'hF, lat, rd, er);
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_load_rdata_unchanged got=%h want=deadbeef", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h1004, 32'h12345678, 4'hF, lat, rd, er);
    access(1'b0, 32'h4, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'h12345678) begin failures++; $display("FAIL wrap_alias got=%h want=12345678", rd); end
    access(1'b0, 32'hFFFF_F010, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wrap_high_bits got=%h want=deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, lat, rd, er);
    access(1'b0, 32'h30, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_load_after_store got=%h want=cafef00d", rd); end
    access(1'b1, 32'h34, 32'h0BADC0DE, 4'hF, lat, rd, er);
    access(1'b0, 32'h30, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_neighbour_intact got=%h want=cafef00d", rd); end
    access(1'b0, 32'h34, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL b2b_second_word got=%h want=0badc0de", rd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h20, 32'h0, 4'hF, lat, rd, er);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h20;
    bus.wdata = 32'hAAAAAAAA;
`ifdef DMEM_BYTE_EN
    bus.be    = 4'hF;
`endif
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      failures++; $display("FAIL abort_async_drop got busy=%b ready=%b want 0/0", bus.busy, bus.ready);
    end
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset abort of store addr=00000020 wdata=aaaaaaaa");
    access(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL abort_no_write got=%h want=00000000", rd); end
  endtask

`ifdef DMEM_BYTE_EN
  task automatic test_byte_en();
    int lat; logic [31:0] rd; logic er;
    access(1'b1, 32'h20, 32'h11223344, 4'b1111, lat, rd, er);
    access(1'b1, 32'h20, 32'h0000AB00, 4'b0010, lat, rd, er);
    access(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, er);
    checks++;
    if (rd !== 32'h1122AB44) begin failures++; $display("FAIL be_single_lane got=%h want=1122ab44", rd); end
    access(1'b1, 32'h21, 32'h0000FFFF, 4'b0011, lat, rd, er);
    checks++;
    if (er !== 1'b1) begin failures++; $display("FAIL be_half_mis_err got=%b want=1", er); end
    access(1'b1, 32'h23, 32'h99000000, 4'b1000, lat, rd, er);
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL be_byte_no_align got=%b want=0", er); end
    access(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    access(1'b0, 32'h20, 32'h0, 4'b1111, lat, rd, er);
    checks++;
    if (rd !== 32'h9922AB44) begin failures++; $display("FAIL be_merge got=%h want=9922ab44", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
`ifdef DMEM_BYTE_EN
    test_byte_en();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
